// File: rtl/mem_ctrl.sv
// Two-port memory arbiter/sequencer in front of the 64-bit Memory block (two-cycle read, one-cycle write).
// Optional feature MEM_CTRL_ERR_EN: misaligned d-port requests return an error instead of being aligned down.
module mem_ctrl #(
  parameter int ADDR_W       = 24,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [63:0]       i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [1:0]        d_req_size,
  input  logic [63:0]       d_req_wdata,
  output logic              d_rsp_valid,
  output logic [63:0]       d_rsp_rdata,
  output logic              d_rsp_err,
  output logic [ADDR_W-4:0] mem_addr,
  inout  wire  [63:0]       mem_data,
  output logic [7:0]        mem_mask,
  output logic [2:0]        mem_shift,
  output logic              mem_rw,
  output logic              mem_enable
);

  typedef enum logic [1:0] {IDLE, RD_A, RD_D, WR} state_t;
  state_t state, state_nx;

  logic [3:0]        starve_cnt;
  logic [ADDR_W-4:0] req_word;
  logic              req_is_i;
  logic [2:0]        req_off;
  logic [1:0]        req_size;
  logic [7:0]        req_mask;
  logic [63:0]       req_wbus;

  logic        idle, i_pri;
  logic [2:0]  d_off, d_lo, d_off_eff;
  logic [7:0]  d_bmask, d_mask;
  logic [63:0] d_wbus, rd_shift, rd_mask;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^i_req_addr[2:0];

  always_comb begin
    d_lo    = 3'd0;
    d_bmask = 8'h01;
    case (d_req_size)
      2'd0: begin d_lo = 3'd0; d_bmask = 8'h01; end
      2'd1: begin d_lo = 3'd1; d_bmask = 8'h03; end
      2'd2: begin d_lo = 3'd3; d_bmask = 8'h0F; end
      default: begin d_lo = 3'd7; d_bmask = 8'hFF; end
    endcase
  end

  assign d_off = d_req_addr[2:0];
`ifdef MEM_CTRL_ERR_EN
  logic d_misal;
  assign d_misal   = |(d_off & d_lo);
  assign d_off_eff = d_off;
`else
  assign d_off_eff = d_off & ~d_lo;
  assign d_rsp_err = 1'b0;
`endif
  assign d_mask = d_bmask << d_off_eff;
  assign d_wbus = d_req_wdata << {d_off_eff, 3'b000};

  // d-port has priority unless the i-port has waited through STARVE_LIMIT d grants
  assign idle        = (state == IDLE);
  assign i_pri       = i_req_valid && (starve_cnt == 4'(STARVE_LIMIT));
  assign d_req_ready = idle && d_req_valid && !i_pri;
  assign i_req_ready = idle && i_req_valid && !d_req_ready;

  always_comb begin
    rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (req_size)
      2'd0: rd_mask = 64'h0000_0000_0000_00FF;
      2'd1: rd_mask = 64'h0000_0000_0000_FFFF;
      2'd2: rd_mask = 64'h0000_0000_FFFF_FFFF;
      default: rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end
  assign rd_shift = mem_data >> {req_off, 3'b000};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_req_ready) state_nx = RD_A;
        else if (d_req_ready) begin
`ifdef MEM_CTRL_ERR_EN
          if (d_misal) state_nx = IDLE;
          else state_nx = d_req_we ? WR : RD_A;
`else
          state_nx = d_req_we ? WR : RD_A;
`endif
        end
      end
      RD_A:    state_nx = RD_D;
      RD_D:    state_nx = IDLE;
      WR:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= 64'd0;
      d_rsp_valid <= 1'b0;
      d_rsp_rdata <= 64'd0;
`ifdef MEM_CTRL_ERR_EN
      d_rsp_err   <= 1'b0;
`endif
      req_word    <= '0;
      req_is_i    <= 1'b0;
      req_off     <= 3'd0;
      req_size    <= 2'd0;
      req_mask    <= 8'd0;
      req_wbus    <= 64'd0;
    end else begin
      state       <= state_nx;
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= 64'd0;
      d_rsp_valid <= 1'b0;
      d_rsp_rdata <= 64'd0;
`ifdef MEM_CTRL_ERR_EN
      d_rsp_err   <= 1'b0;
`endif
      if (!i_req_valid || i_req_ready) starve_cnt <= 4'd0;
      else if (d_req_ready) starve_cnt <= starve_cnt + 4'd1;

      if (i_req_ready) begin
        req_word <= i_req_addr[ADDR_W-1:3];
        req_is_i <= 1'b1;
        req_off  <= 3'd0;
        req_size <= 2'd3;
        req_mask <= 8'hFF;
        req_wbus <= 64'd0;
      end else if (d_req_ready) begin
        req_word <= d_req_addr[ADDR_W-1:3];
        req_is_i <= 1'b0;
        req_off  <= d_off_eff;
        req_size <= d_req_size;
        req_mask <= d_mask;
        req_wbus <= d_wbus;
`ifdef MEM_CTRL_ERR_EN
        if (d_misal) begin
          d_rsp_valid <= 1'b1;
          d_rsp_err   <= 1'b1;
        end
`endif
      end

      if (state == RD_D) begin
        if (req_is_i) begin
          i_rsp_valid <= 1'b1;
          i_rsp_data  <= mem_data;
        end else begin
          d_rsp_valid <= 1'b1;
          d_rsp_rdata <= rd_shift & rd_mask;
        end
      end
      if (state == WR) d_rsp_valid <= 1'b1;
    end
  end

  // memory strobes decode straight from state so a WR cycle commits even under reset
  assign mem_enable = !idle;
  assign mem_rw     = (state == WR);
  assign mem_addr   = idle ? '0 : req_word;
  assign mem_mask   = idle ? 8'd0 : req_mask;
  assign mem_shift  = 3'd0;
  assign mem_data   = (state == WR) ? req_wbus : 64'bz;

endmodule
